pc_ras_gen: RTL
===============

# pc_ras_gen

Parametrised successor to the fetch-stage program counter: a registered PC with configurable width, increment step and reset/exception vectors. It selects the next PC from exception, branch redirect, call and return sources, and adds an internal return-address stack (RAS) that predicts return targets. It sits at the head of the fetch stage, feeding the PC and the sequential next address (PC4) to instruction memory and the decode stage.

## Interface
- ADDR_W, 32, PC / address width in bits
- STEP, 1, sequential increment (1 = word addressing, as in the current datapath)
- RESET_VEC, 0, PC value on reset
- EXC_VEC, 'h10, PC value on exception entry
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- stall  in  1  hold PC; blocks call/ret/sequential advance
- exc_valid  in  1  exception entry request
- redir_valid  in  1  branch/jump correction from execute
- redir_pc  in  ADDR_W  correction target
- call_valid  in  1  call decoded at current PC
- call_target  in  ADDR_W  call destination
- ret_valid  in  1  return decoded at current PC
- ret_fallback  in  ADDR_W  return target used when the RAS is empty
- PC  out  ADDR_W  current fetch address (registered)
- PC4  out  ADDR_W  PC + STEP, combinational, modulo 2^ADDR_W
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries (registered)
- ras_miss  out  1  one-cycle pulse: a return was taken with the RAS empty

## Operation
- Next-PC priority, highest first:
  - **exc_valid:** EXC_VEC. Also clears the RAS: count set to 0, top pointer set to 0.
  - **redir_valid:** redir_pc. RAS is unchanged.
  - **stall:** hold PC. call and ret are ignored.
  - **ret_valid:**
    - RAS non-empty: take the top entry, pop, count decrements.
    - RAS empty: take ret_fallback, count stays 0, ras_miss=1 next cycle.
  - **call_valid:** call_target. Push PC4 as the return address.
  - **otherwise:** PC4.
- exc_valid and redir_valid override stall. This matches how later pipeline stages flush the front end.
- When call_valid and ret_valid are both high, ret wins and call is ignored. Decode guarantees this does not happen; the rule only makes the behaviour deterministic.
- RAS is a circular buffer addressed by a top pointer:
  - Push writes at top+1, then advances top; the pointer wraps modulo RAS_DEPTH.
  - When full, a push overwrites the oldest entry and count saturates at RAS_DEPTH.
  - Pop reads at top, then decrements top, also wrapping.
- When call or ret is lost to exc or redir, the RAS is not modified.
- Arithmetic: PC4 and pushed return addresses are truncated to ADDR_W bits. PC = max value wraps to STEP-1.

## Timing
- **Reset (rst high, asynchronous, any time):**
  - PC=RESET_VEC, so PC4=RESET_VEC+STEP.
  - ras_count=0, ras_miss=0, top pointer=0.
  - RAS entry contents are don't-care.
- **First edge after rst falls:** PC advances per the normal priority rules.
- **Latency:** a request sampled at edge N appears on PC after edge N. PC4 follows PC in the same cycle.
- **RAS state:** push/pop take effect at the same edge as the PC update. A ret in the cycle immediately after a call returns that call's PC4.
- **ras_miss:** high for exactly the cycle following an empty-stack return, then low unless another miss occurs.
- **Reset during pending requests:** reset wins; in-flight call/ret/redir are discarded.

## Test plan
- **Reset and sequential fetch:** assert rst mid-run with PC=0x40 -> PC=0 immediately. Release -> PC 0,1,2,3 on successive edges, PC4=PC+1.
- **Stall vs redirect:** stall=1 with call_valid=1 -> PC holds and ras_count unchanged. Then stall=1, redir_valid=1, redir_pc=0x200 -> PC=0x200 next cycle.
- **Call/return pairing:**
  - At PC=0x10, call_target=0x80 -> PC=0x80, ras_count=1.
  - At PC=0x80, call_target=0xC0 -> ras_count=2.
  - Two rets -> PC=0x81, then PC=0x11; ras_count=0; ras_miss never set.
- **RAS overflow (DEPTH=4):** 5 nested calls from PCs 0x0..0x4 -> ras_count=4. Pops return 0x5,0x4,0x3,0x2, then the 5th ret takes ret_fallback=0x300 with a ras_miss pulse.
- **Exception:** with ras_count=3, exc_valid=1 together with ret_valid=1 -> PC=EXC_VEC, ras_count=0. A following ret -> PC=ret_fallback, ras_miss=1 for one cycle.
- **Wrap:** ADDR_W=8, PC=0xFF, no requests -> PC=0x00, PC4=0x01. A call at PC=0xFF pushes 0x00.

Source files
------------

// File: rtl/pc_ras_gen.sv
// Fetch-stage program counter with prioritised next-PC selection and a circular
// return-address stack that predicts return targets.
module pc_ras_gen #(
  parameter int unsigned            ADDR_W    = 32,
  parameter int unsigned            STEP      = 1,
  parameter logic [ADDR_W-1:0]      RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]      EXC_VEC   = 'h10,
  parameter int unsigned            RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         exc_valid,
  input  logic                         redir_valid,
  input  logic [ADDR_W-1:0]            redir_pc,
  input  logic                         call_valid,
  input  logic [ADDR_W-1:0]            call_target,
  input  logic                         ret_valid,
  input  logic [ADDR_W-1:0]            ret_fallback,
  output logic [ADDR_W-1:0]            PC,
  output logic [ADDR_W-1:0]            PC4,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_miss
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] StepW = ADDR_W'(STEP);
  localparam logic [CntW-1:0]   CntMax = CntW'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              miss_q, miss_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              push;
  logic [PtrW-1:0]   wr_ptr;
  logic [ADDR_W-1:0] pc_seq;

  assign pc_seq = pc_q + StepW;
  assign wr_ptr = top_q + PtrW'(1);

  always_comb begin
    pc_d   = pc_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    miss_d = 1'b0;
    push   = 1'b0;
    if (exc_valid) begin
      pc_d  = EXC_VEC;
      top_d = '0;
      cnt_d = '0;
    end else if (redir_valid) begin
      pc_d = redir_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret_valid) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d   = ret_fallback;
        miss_d = 1'b1;
      end
    end else if (call_valid) begin
      pc_d  = call_target;
      push  = 1'b1;
      top_d = wr_ptr;
      // A full stack overwrites its oldest entry, so the count saturates.
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end else begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_VEC;
      top_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  // Entry contents are don't-care after reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[wr_ptr] <= pc_seq;
    end
  end

  assign PC        = pc_q;
  assign PC4       = pc_seq;
  assign ras_count = cnt_q;
  assign ras_miss  = miss_q;

endmodule
